// File: rtl/debug_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : debug_step_controller
// Description : Debug command FSM that steps or runs the pipeline through a
//               registered enable and streams a captured probe word as bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_step_controller #(
    parameter int DATA_W     = 32,
    parameter int NUM_PROBES = 32,
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    input  logic [7:0]                   cmd_code,
    output logic                         cmd_ready,
    input  logic [NUM_PROBES*DATA_W-1:0] probes,
    input  logic                         bp_hit,
    output logic                         pipe_en,
    output logic                         halted,
    output logic [CNT_W-1:0]             cycle_count,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready
);

    localparam int         NBYTES  = DATA_W / 8;
    localparam int         BIDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_STEP = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_RUN  = 2'd2,
        S_SEND = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [BIDX_W-1:0]   byte_q, byte_d;
    logic [CNT_W-1:0]    count_q;
    logic [DATA_W-1:0]   sel_w;
    logic [1:0]          op_w;
    logic [5:0]          idx_w;
    logic                accept_w;
    logic                tx_fire_w;
    logic                last_w;

    assign op_w      = cmd_code[7:6];
    assign idx_w     = cmd_code[5:0];
    assign accept_w  = cmd_valid && cmd_ready;
    assign tx_fire_w = tx_valid && tx_ready;
    assign last_w    = (byte_q == BIDX_W'(NBYTES - 1));

    // Readout source: probe channel, then the cycle counter, then zero.
    always_comb begin
        sel_w = '0;
        for (int i = 0; i < NUM_PROBES; i++) begin
            if (idx_w == 6'(i)) begin
                sel_w = probes[i*DATA_W +: DATA_W];
            end
        end
        if (idx_w == 6'(NUM_PROBES)) begin
            sel_w = DATA_W'(count_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        byte_d      = byte_q;
        cmd_ready   = (state_q == S_IDLE) || (state_q == S_RUN);
        pipe_en     = (state_q == S_STEP) || (state_q == S_RUN);
        halted      = !pipe_en;
        tx_valid    = (state_q == S_SEND);
        tx_data     = tx_valid ? shadow_q[7:0] : 8'h00;
        cycle_count = count_q;

        case (state_q)
            S_IDLE: begin
                if (accept_w) begin
                    case (op_w)
                        OP_READ: begin
                            shadow_d = sel_w;
                            byte_d   = '0;
                            state_d  = S_SEND;
                        end
                        OP_STEP: state_d = S_STEP;
                        OP_RUN:  state_d = S_RUN;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_STEP: state_d = S_IDLE;
            S_RUN: begin
                // Non-HALT commands are consumed here without effect.
                if (bp_hit || (accept_w && (op_w == OP_HALT))) begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                // Shadow shifts right so the current byte is always [7:0].
                if (tx_fire_w) begin
                    shadow_d = shadow_q >> 8;
                    byte_d   = byte_q + BIDX_W'(1);
                    if (last_w) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            byte_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            byte_q   <= byte_d;
            if (pipe_en) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_step_controller
// Description : Directed and randomized checks of debug_step_controller
//               against a behavioural model of commands, counter and readout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_step_controller;

    localparam int DATA_W     = 32;
    localparam int NUM_PROBES = 32;
    localparam int CNT_W      = 32;
    localparam int NBYTES     = DATA_W / 8;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         cmd_valid;
    logic [7:0]                   cmd_code;
    logic                         cmd_ready;
    logic [NUM_PROBES*DATA_W-1:0] probes;
    logic                         bp_hit;
    logic                         pipe_en;
    logic                         halted;
    logic [CNT_W-1:0]             cycle_count;
    logic [7:0]                   tx_data;
    logic                         tx_valid;
    logic                         tx_ready;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] pv [NUM_PROBES];
    logic [31:0] m_cnt;

    debug_step_controller #(
        .DATA_W     (DATA_W),
        .NUM_PROBES (NUM_PROBES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_ready   (cmd_ready),
        .probes      (probes),
        .bp_hit      (bp_hit),
        .pipe_en     (pipe_en),
        .halted      (halted),
        .cycle_count (cycle_count),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
        end
    endtask

    task automatic load_probes();
        for (int i = 0; i < NUM_PROBES; i++) probes[i*DATA_W +: DATA_W] = pv[i];
    endtask

    task automatic randomize_probes();
        for (int i = 0; i < NUM_PROBES; i++) pv[i] = $urandom;
        load_probes();
    endtask

    function automatic logic [31:0] model_word(input int idx);
        if (idx < NUM_PROBES)  return pv[idx];
        if (idx == NUM_PROBES) return m_cnt;
        return 32'h0;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_pipe_en"},   64'(pipe_en),     64'(0));
        chk({tag, "_halted"},    64'(halted),      64'(1));
        chk({tag, "_cmd_ready"}, 64'(cmd_ready),   64'(1));
        chk({tag, "_tx_valid"},  64'(tx_valid),    64'(0));
        chk({tag, "_tx_data"},   64'(tx_data),     64'(0));
        chk({tag, "_count"},     64'(cycle_count), 64'(m_cnt));
    endtask

    task automatic do_reset();
        reset = 1'b1; cmd_valid = 1'b0; bp_hit = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_cnt = 0;
        check_idle("reset");
    endtask

    task automatic issue(input logic [7:0] code);
        cmd_valid = 1'b1;
        cmd_code  = code;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_code  = 8'($urandom);
    endtask

    task automatic do_step();
        chk("step_ready_before", 64'(cmd_ready), 64'(1));
        issue({2'b01, 6'($urandom)});
        chk("step_pipe_en",   64'(pipe_en),     64'(1));
        chk("step_halted",    64'(halted),      64'(0));
        chk("step_cmd_ready", 64'(cmd_ready),   64'(0));
        chk("step_count_pre", 64'(cycle_count), 64'(m_cnt));
        // A RUN offered while busy must be ignored, not queued.
        cmd_valid = 1'b1; cmd_code = 8'h80;
        @(negedge clk);
        cmd_valid = 1'b0;
        m_cnt = m_cnt + 1;
        check_idle("step_after");
        @(negedge clk);
        check_idle("step_settle");
    endtask

    // mode: 0 ready high, 1 toggle 0/1, 2 random. abort_at: byte index at which
    // reset is applied, or -1.
    task automatic do_read(input int idx, input int mode, input bit scramble, input int abort_at);
        logic [31:0] req_w;
        logic [7:0]  got [$];
        logic [7:0]  prev_data;
        bit          prev_stall;
        bit          r;
        int          cyc;
        req_w      = model_word(idx);
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        cyc        = 0;
        chk("read_ready_before", 64'(cmd_ready), 64'(1));
        issue({2'b00, 6'(idx)});
        chk("read_first_valid", 64'(tx_valid), 64'(1));
        while (got.size() < NBYTES && cyc < 200) begin
            chk("read_pipe_en_low", 64'(pipe_en),   64'(0));
            chk("read_busy",        64'(cmd_ready), 64'(0));
            chk("read_valid",       64'(tx_valid),  64'(1));
            if (prev_stall) chk("read_hold", 64'(tx_data), 64'(prev_data));
            if (abort_at == got.size()) begin
                reset = 1'b1; cmd_valid = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                m_cnt = 0;
                check_idle("read_abort");
                return;
            end
            cmd_valid = (cyc == 0);
            cmd_code  = 8'h40;
            case (mode)
                0:       r = 1'b1;
                1:       r = cyc[0];
                default: r = 1'($urandom_range(0, 1));
            endcase
            tx_ready = r;
            if (r) got.push_back(tx_data);
            prev_stall = !r;
            prev_data  = tx_data;
            @(negedge clk);
            if (scramble && got.size() == 1) randomize_probes();
            cyc++;
        end
        cmd_valid = 1'b0;
        tx_ready  = 1'b0;
        chk("read_no_timeout", 64'(cyc < 200), 64'(1));
        check_idle("read_done");
        for (int k = 0; k < NBYTES; k++) begin
            chk("read_byte", 64'((k < got.size()) ? got[k] : 8'hxx), 64'(req_w[8*k +: 8]));
        end
    endtask

    // stop_kind: 0 HALT, 1 bp_hit, 2 both together. step_at: cycle of a
    // discarded command (0 = none). abort: stop with reset instead.
    task automatic do_run(input int n, input int step_at, input int stop_kind, input bit abort);
        chk("run_ready_before", 64'(cmd_ready), 64'(1));
        bp_hit = 1'b1;
        issue(8'h80 | 8'($urandom_range(0, 63)));
        bp_hit = 1'b0;
        for (int i = 1; i <= n; i++) begin
            chk("run_pipe_en",   64'(pipe_en),     64'(1));
            chk("run_halted",    64'(halted),      64'(0));
            chk("run_cmd_ready", 64'(cmd_ready),   64'(1));
            chk("run_count",     64'(cycle_count), 64'(m_cnt + 32'(i - 1)));
            cmd_valid = 1'b0;
            bp_hit    = 1'b0;
            if (i == step_at) begin
                cmd_valid = 1'b1;
                cmd_code  = {2'($urandom_range(0, 2)), 6'($urandom)};
            end
            if (i == n) begin
                if (abort) begin
                    reset = 1'b1;
                end else begin
                    if (stop_kind != 1) begin cmd_valid = 1'b1; cmd_code = 8'hC0; end
                    if (stop_kind != 0) bp_hit = 1'b1;
                end
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        bp_hit    = 1'b0;
        reset     = 1'b0;
        m_cnt     = abort ? 32'h0 : m_cnt + 32'(n);
        check_idle("run_stop");
        @(negedge clk);
        chk("run_settle_pipe_en", 64'(pipe_en),     64'(0));
        chk("run_settle_count",   64'(cycle_count), 64'(m_cnt));
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_code = 8'h00; bp_hit = 1'b0; tx_ready = 1'b0;
        for (int i = 0; i < NUM_PROBES; i++) pv[i] = 32'h0;
        load_probes();
        m_cnt = 0;
        @(negedge clk);

        do_reset();
        do_step();

        randomize_probes();
        pv[5] = 32'hDEADBEEF; load_probes();
        do_read(5, 0, 1'b1, -1);
        pv[5] = 32'hDEADBEEF; load_probes();
        do_read(5, 1, 1'b0, -1);

        do_run(10, 5, 0, 1'b0);

        do_reset();
        do_run(4, 0, 1, 1'b0);
        do_read(NUM_PROBES, 0, 1'b0, -1);
        do_read(63, 2, 1'b0, -1);

        issue(8'hC0);
        check_idle("halt_idle");

        do_run(3, 1, 2, 1'b0);
        do_run(1, 0, 1, 1'b0);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: do_step();
                1: begin
                    randomize_probes();
                    do_read($urandom_range(0, 63), $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
                end
                2: begin
                    int n;
                    n = $urandom_range(1, 15);
                    do_run(n, (n > 1) ? $urandom_range(0, n - 1) : 0, $urandom_range(0, 2), 1'b0);
                end
                default: begin
                    issue(8'hC0 | 8'($urandom_range(0, 63)));
                    check_idle("rand_halt");
                end
            endcase
            if (it % 8 == 7) do_read(NUM_PROBES, 0, 1'b0, -1);
        end

        randomize_probes();
        do_read(5, 0, 1'b0, 2);
        do_run(6, 0, 0, 1'b1);
        do_read(NUM_PROBES, 0, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
